// File: rtl/otter_hazard_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
// The package has no clocked logic and no backpressure.
package otter_hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Instruction that a setnull loads into a pipeline register (addi x0, x0, 0).
  localparam logic [31:0] OTTER_NOP = 32'h00000013;

  // The younger producer (EX/MEM) wins over MEM/WB, and x0 never forwards.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_regwrite,
    input logic [4:0] wb_rd,
    input logic       wb_regwrite
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/otter_hazard_unit_perf.sv
// hazard_perf_counters: counts LU_STALL, FLUSH and MEM_WAIT cycles from the next-state value.
// One-cycle latency; free-running 32-bit wrap; no backpressure.
module hazard_perf_counters
  import otter_hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  hz_state_nxt,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_memwait
);

  logic [31:0] stall_d,   stall_q;
  logic [31:0] flush_d,   flush_q;
  logic [31:0] memwait_d, memwait_q;

  always_comb begin
    stall_d   = stall_q;
    flush_d   = flush_q;
    memwait_d = memwait_q;
    case (hz_state_t'(hz_state_nxt))
      LU_STALL: stall_d   = stall_q + 32'd1;
      FLUSH:    flush_d   = flush_q + 32'd1;
      MEM_WAIT: memwait_d = memwait_q + 32'd1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= 32'd0;
      flush_q   <= 32'd0;
      memwait_q <= 32'd0;
    end else begin
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      memwait_q <= memwait_d;
    end
  end

  assign perf_stall   = stall_q;
  assign perf_flush   = flush_q;
  assign perf_memwait = memwait_q;

endmodule

// File: rtl/otter_hazard_unit.sv
// OTTER hazard controller: stage enables/setnulls, EX forwarding, ID write-through bypass; OTTER_HAZARD_PERF_EN adds counters.
// Controls are zero-latency combinational; hz_state, watchdog and counters lag one cycle; dmem_busy freezes every stage.
module otter_hazard_unit #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        ex_branch_taken,
  input  logic        dmem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_setnull,
  output logic        id_ex_setnull,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        id_bypass_a,
  output logic        id_bypass_b,
  output logic [1:0]  hz_state,
  output logic        mem_timeout,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_memwait
);

  import otter_hazard_pkg::*;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  hz_state_t  hz_state_d, hz_state_q;
  logic [7:0] wait_cnt_d, wait_cnt_q;
  logic       mem_timeout_d, mem_timeout_q;
  logic       lu_hit;

  always_comb begin
    lu_hit = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    if (dmem_busy) begin
      hz_state_d = MEM_WAIT;
    end else if (ex_branch_taken) begin
      hz_state_d = FLUSH;
    end else if (lu_hit) begin
      hz_state_d = LU_STALL;
    end else begin
      hz_state_d = RUN;
    end
  end

  // Reset gates the combinational controls so the pipeline is held as soon as rst_n falls.
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_setnull = 1'b0;
    id_ex_setnull = 1'b0;
    if (rst_n) begin
      case (hz_state_d)
        MEM_WAIT: ;
        FLUSH: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_setnull = 1'b1;
          id_ex_setnull = 1'b1;
        end
        LU_STALL: begin
          {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
          id_ex_setnull = 1'b1;
        end
        default: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      endcase
    end
  end

  always_comb begin
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
    id_bypass_a = 1'b0;
    id_bypass_b = 1'b0;
    if (rst_n) begin
      fwd_a_sel   = fwd_select(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b_sel   = fwd_select(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      id_bypass_a = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1);
      id_bypass_b = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2);
    end
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (dmem_busy) begin
      wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 8'd1;
    end
    mem_timeout_d = mem_timeout_q || (dmem_busy && (wait_cnt_d == WAIT_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_state_q    <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      hz_state_q    <= hz_state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz_state    = hz_state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef OTTER_HAZARD_PERF_EN
  hazard_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_state_nxt (hz_state_d),
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush),
    .perf_memwait (perf_memwait)
  );
`else
  assign perf_stall   = 32'd0;
  assign perf_flush   = 32'd0;
  assign perf_memwait = 32'd0;
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Randomized bench for otter_hazard_unit against a cycle-level behavioural model, plus directed scenarios.
module tb_otter_hazard_unit;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
  logic        mem_regwrite, wb_regwrite, ex_branch_taken, dmem_busy;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_setnull, id_ex_setnull, id_bypass_a, id_bypass_b, mem_timeout;
  logic [1:0]  fwd_a_sel, fwd_b_sel, hz_state;
  logic [31:0] perf_stall, perf_flush, perf_memwait;

  always #5 clk = ~clk;

  otter_hazard_unit #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .ex_branch_taken(ex_branch_taken),
    .dmem_busy(dmem_busy), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_setnull(if_id_setnull),
    .id_ex_setnull(id_ex_setnull), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b), .hz_state(hz_state),
    .mem_timeout(mem_timeout), .perf_stall(perf_stall), .perf_flush(perf_flush),
    .perf_memwait(perf_memwait)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_state;
  int          m_busy_run;
  bit          m_timeout;
  int unsigned m_stall, m_flush, m_wait;

  // Indexed by condition 0..3: {pc,if_id,id_ex,ex_mem,mem_wb} and {if_id_setnull,id_ex_setnull}
  localparam logic [4:0] EXP_EN [4] = '{5'b11111, 5'b00111, 5'b11111, 5'b00000};
  localparam logic [1:0] EXP_SN [4] = '{2'b00, 2'b01, 2'b11, 2'b00};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cond_now();
    if (dmem_busy) return 3;
    if (ex_branch_taken) return 2;
    if (ex_memread && ex_regwrite && ex_rd != 0 &&
        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))) return 1;
    return 0;
  endfunction

  function automatic int fwd_exp(input logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit byp_exp(input logic [4:0] rs);
    return wb_regwrite && wb_rd != 0 && wb_rd == rs;
  endfunction

  task automatic model_reset();
    m_state = 0; m_busy_run = 0; m_timeout = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread} = '0;
    {mem_regwrite, wb_regwrite, ex_branch_taken, dmem_busy} = '0;
  endtask

  task automatic check_outputs();
    int c;
    c = cond_now();
    check_val("enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, EXP_EN[c]);
    check_val("setnulls", {if_id_setnull, id_ex_setnull}, EXP_SN[c]);
    check_val("fwd_a", fwd_a_sel, fwd_exp(ex_rs1));
    check_val("fwd_b", fwd_b_sel, fwd_exp(ex_rs2));
    check_val("bypass", {id_bypass_a, id_bypass_b}, {byp_exp(id_rs1), byp_exp(id_rs2)});
    check_val("hz_state", hz_state, m_state);
    check_val("timeout", mem_timeout, m_timeout);
`ifdef OTTER_HAZARD_PERF_EN
    check_val("perf_stall", perf_stall, m_stall);
    check_val("perf_flush", perf_flush, m_flush);
    check_val("perf_memwait", perf_memwait, m_wait);
`else
    check_val("perf_off", perf_stall | perf_flush | perf_memwait, 0);
`endif
  endtask

  task automatic model_edge();
    int c;
    c = cond_now();
    if (c == 1) m_stall++;
    if (c == 2) m_flush++;
    if (c == 3) m_wait++;
    if (dmem_busy) begin
      m_busy_run++;
      if (m_busy_run >= MAXW) m_timeout = 1;
    end else begin
      m_busy_run = 0;
    end
    m_state = c;
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic run_cycle();
    #3;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs(input int busy_pct);
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
    wb_rd  = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
    mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
    ex_branch_taken = ($urandom_range(0, 99) < 20);
    dmem_busy = ($urandom_range(0, 99) < busy_pct);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    // Inputs that would produce RUN and a bypass if reset did not gate them
    wb_regwrite = 1'b1; wb_rd = 5'd3; id_rs1 = 5'd3;
    #2;
    check_val("rst_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
    check_val("rst_bypass", {id_bypass_a, id_bypass_b, fwd_a_sel, fwd_b_sel}, 0);
    check_val("rst_state", {hz_state, mem_timeout}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_inputs();

    // Load-use on rs1
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    #1;
    check_val("lu_pc_en", pc_en, 0);
    check_val("lu_if_id_en", if_id_en, 0);
    check_val("lu_id_ex_setnull", id_ex_setnull, 1);
    #(-0);
    #0;
    // align back to posedge+1 timing before handing to run_cycle
    run_cycle();
    ex_memread = 0; ex_rd = 5'd0;
    check_val("lu_state", hz_state, 1);
    run_cycle();
    check_val("lu_done", hz_state, 0);

    // x0 destination and unused source give no stall
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
    #1; check_val("x0_no_stall", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    run_cycle();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 0;
    #1; check_val("unused_no_stall", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    run_cycle();

    // Branch with concurrent load-use: flush wins
    id_use_rs1 = 1; ex_branch_taken = 1;
    #1; check_val("br_pc_en", pc_en, 1);
    check_val("br_setnulls", {if_id_setnull, id_ex_setnull}, 2'b11);
    run_cycle();
    clear_inputs();
    check_val("br_state", hz_state, 2);

    // Forwarding priority and ID bypass
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; mem_regwrite = 1; wb_regwrite = 1;
    #1; check_val("fwd_mem", fwd_a_sel, 2'b01);
    mem_regwrite = 0;
    #1; check_val("fwd_wb", fwd_a_sel, 2'b10);
    wb_rd = 5'd9; id_rs2 = 5'd9;
    #1; check_val("bypass_b", id_bypass_b, 1);
    run_cycle();
    clear_inputs();

    // Watchdog: four busy edges set the sticky flag
    dmem_busy = 1;
    repeat (MAXW) run_cycle();
    check_val("timeout_set", mem_timeout, 1);
    dmem_busy = 0;
    run_cycle();
    check_val("timeout_sticky", mem_timeout, 1);
`ifdef OTTER_HAZARD_PERF_EN
    check_val("memwait_cnt", perf_memwait, MAXW);
`endif

    // Randomized traffic, alternating light and heavy memory stalls
    for (int i = 0; i < 600; i++) begin
      randomize_inputs(((i / 50) % 2 == 1) ? 75 : 10);
      run_cycle();
    end

    // Reset pulsed mid-MEM_WAIT takes effect without a clock edge
    clear_inputs();
    rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_busy = 1; ex_branch_taken = 1;
    repeat (MAXW + 1) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_state", hz_state, 0);
    check_val("mid_rst_timeout", mem_timeout, 0);
    check_val("mid_rst_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_setnull, id_ex_setnull}, 0);
    check_val("mid_rst_perf", perf_stall | perf_flush | perf_memwait, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Branch held through MEM_WAIT applies as a flush once busy drops
    run_cycle();
    dmem_busy = 0;
    #1; check_val("late_flush", {if_id_setnull, id_ex_setnull}, 2'b11);
    run_cycle();
    clear_inputs();
    for (int i = 0; i < 100; i++) begin
      randomize_inputs(30);
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_hazard_unit.md
# otter_hazard_unit

Pipeline hazard controller for the five-stage OTTER core. It generates the `enable` and `setnull` controls consumed by the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, where `setnull` loads NOP 0x00000013. It also produces operand-forwarding selects and the register-file write-through bypass. It sits beside the datapath, reads the stage destination/source fields, and decides per cycle between run, load-use stall, branch flush and data-memory freeze.

## Interface
- `MEM_WAIT_MAX`, default 255: consecutive `dmem_busy` cycles before `mem_timeout` sets; must be ≥1 and <256.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in 5 each; `id_use_rs1`, `id_use_rs2` in 1 each: decode-stage sources and their used flags.
- `ex_rs1`, `ex_rs2` in 5 each: ID/EX source fields.
- `ex_rd` in 5; `ex_regwrite`, `ex_memread` in 1 each: ID/EX destination, write and load flags.
- `mem_rd` in 5; `mem_regwrite` in 1: EX/MEM destination and write flag.
- `wb_rd` in 5; `wb_regwrite` in 1: MEM/WB destination, which is the register-file write port.
- `ex_branch_taken` in 1: branch or jump resolved taken in EX.
- `dmem_busy` in 1: data memory not ready.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: stage enables.
- `if_id_setnull`, `id_ex_setnull` out 1 each: load NOP.
- `fwd_a_sel`, `fwd_b_sel` out 2 each: EX operand source.
- `id_bypass_a`, `id_bypass_b` out 1 each: ID read takes WB data.
- `hz_state` out 2: registered state.
- `mem_timeout` out 1: sticky watchdog flag.
- `perf_stall`, `perf_flush`, `perf_memwait` out 32 each: performance counters.

## Operation
- Pipeline controls are combinational and evaluated in priority order.
  1. MEM_WAIT (`dmem_busy`=1): all five enables 0; both setnulls 0.
  2. FLUSH (`ex_branch_taken`=1): all enables 1; `if_id_setnull`=1 and `id_ex_setnull`=1.
  3. LU_STALL: true when `ex_memread & ex_regwrite & ex_rd!=0` and either `id_use_rs1 & id_rs1==ex_rd` or `id_use_rs2 & id_rs2==ex_rd`. Outputs: `pc_en`=0, `if_id_en`=0, `id_ex_setnull`=1, remaining enables 1.
  4. RUN: all enables 1; setnulls 0.
- Encodings: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3. The state register captures the selected condition each edge; `hz_state` shows the previous cycle's decision.
- `fwd_a_sel` uses `ex_rs1`:
  - 01 if `mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1`;
  - else 10 if `wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1`;
  - else 00.
- `fwd_b_sel` is the same function of `ex_rs2`. Value 11 is never driven.
- `id_bypass_a` = `wb_regwrite & wb_rd!=0 & wb_rd==id_rs1`. `id_bypass_b` is the same for `id_rs2`. This covers the register file's edge-write versus asynchronous-read gap.
- Register x0 never matches any hazard or forward.
- Watchdog:
  - An 8-bit `wait_cnt` increments each cycle `dmem_busy`=1, saturates at `MEM_WAIT_MAX`, and clears to 0 on any cycle with `dmem_busy`=0.
  - `mem_timeout` sets at the edge where `wait_cnt` reaches `MEM_WAIT_MAX`.
  - Once set, it holds until `rst_n`; it does not affect the pipeline controls.

## Timing
- While `rst_n`=0:
  - all enables and setnulls 0;
  - `fwd_*_sel`=00; `id_bypass_*`=0;
  - `hz_state`=RUN; `wait_cnt`=0; `mem_timeout`=0; perf counters 0.
- Reset assertion takes effect immediately, including mid-MEM_WAIT.
- After release, the first rising edge updates registers.
- Controls, forwards and bypasses have zero latency: same cycle as the inputs.
- `hz_state` and the counters have one-cycle latency.
- A load-use stall lasts exactly one cycle unless a higher priority preempts it.
- A flush is exactly one cycle per taken branch.
- Branch during MEM_WAIT: frozen; the flush applies on the first non-busy cycle.

## Configuration
- `OTTER_HAZARD_PERF_EN` defined:
  - `perf_stall` +1 per LU_STALL cycle;
  - `perf_flush` +1 per FLUSH cycle;
  - `perf_memwait` +1 per MEM_WAIT cycle;
  - each is 32-bit and wraps modulo 2^32.
- Undefined: counters are not instantiated and the three ports are driven to 0.

## Structure
- Package `otter_hazard_pkg`:
  - `hz_state_t` enum (RUN, LU_STALL, FLUSH, MEM_WAIT);
  - `fwd_sel_t` (FWD_RF=00, FWD_MEM=01, FWD_WB=10);
  - `OTTER_NOP` = 32'h00000013.
- One sub-module: `hazard_perf_counters` (clk, rst_n, `hz_state` next value in, three counters out), instantiated only under the macro.

## Test plan
- Load-use: `ex_memread`=1, `ex_regwrite`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 -> `pc_en`=0, `if_id_en`=0, `id_ex_setnull`=1; next cycle `hz_state`=1; following cycle, with the load advanced, RUN.
- Same load with `ex_rd`=0, or with `id_use_rs1`=0 -> no stall, all enables 1.
- Taken branch and load-use together -> `pc_en`=1, both setnulls 1, `hz_state`=2 next cycle.
- Forwarding: `mem_rd`=`wb_rd`=`ex_rs1`=7, both regwrite -> `fwd_a_sel`=01. Drop `mem_regwrite` -> 10. `wb_rd`=`id_rs2`=9, `wb_regwrite`=1 -> `id_bypass_b`=1.
- `dmem_busy` held with `MEM_WAIT_MAX`=4 -> enables 0 throughout; `mem_timeout` 1 after the 4th busy edge and still 1 after busy drops; `perf_memwait`=4 with `OTTER_HAZARD_PERF_EN` defined.
- `rst_n` pulsed low mid-MEM_WAIT -> `hz_state`=0, `mem_timeout`=0, counters 0, enables 0, all immediately, without waiting for a clock edge.
